// File: rtl/waffle_uart_tx.sv
// waffle_uart_tx: memory-mapped 8N1 UART transmitter for the CPU data bus.
// The CPU pushes bytes into TX_DATA, and an 8-deep FIFO queues them.
// A bit-timing FSM shifts each byte out LSB-first on uart_txd.
// irq goes high while the interrupt is enabled and the transmitter has run dry.
module waffle_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BASE_ADDR    = 1000,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        sel,
    output logic        uart_txd,
    output logic        irq
);

    localparam int          PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] TX_ADDR     = 16'(BASE_ADDR);
    localparam logic [15:0] STATUS_ADDR = 16'(BASE_ADDR + 1);
    localparam logic [15:0] CTRL_ADDR   = 16'(BASE_ADDR + 2);
    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  DEPTH       = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [4:0]       count;
    logic             full, empty;

    // Control and status
    logic ie;
    logic overflow;

    // Serialiser state
    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_d;
    logic        baud_end;
    logic        busy;

    // Bus decode
    logic hit_tx, hit_status, hit_ctrl;
    logic push_req, push, pop;

    assign full       = (count == DEPTH);
    assign empty      = (count == 5'd0);
    assign busy       = (state_q != S_IDLE);
    assign baud_end   = (baud_q == BAUD_LAST);
    assign irq        = ie & empty & ~busy;

    assign hit_tx     = (addr == TX_ADDR);
    assign hit_status = (addr == STATUS_ADDR);
    assign hit_ctrl   = (addr == CTRL_ADDR);
    assign push_req   = we & hit_tx;
    // A full FIFO still accepts a byte in the same cycle the serialiser frees a slot
    assign push       = push_req & (~full | pop);

    // FIFO storage write; no reset needed, validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and control register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
            ie       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (we && hit_status && din[3]) begin
                overflow <= 1'b0;
            end
            if (we && hit_ctrl) begin
                ie <= din[0];
            end
        end
    end

    // Registered read port: one-cycle latency, sel marks our address range
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= 8'd0;
            sel  <= 1'b0;
        end else begin
            dout <= 8'd0;
            sel  <= hit_tx | hit_status | hit_ctrl;
            if (hit_status) begin
                dout <= {count[3:0], overflow, busy, empty, full};
            end else if (hit_ctrl) begin
                dout <= {7'd0, ie};
            end
        end
    end

    // Serialiser state register; uart_txd is registered so the line never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            uart_txd <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            uart_txd <= txd_d;
        end
    end

    // Serialiser next state: start bit, 8 data bits LSB-first, stop bit, chaining frames
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = 16'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_waffle_uart_tx.sv
// tb_waffle_uart_tx: directed bench for waffle_uart_tx with CLKS_PER_BIT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_waffle_uart_tx;

    localparam int          CPB     = 4;
    localparam logic [15:0] NO_ADDR = 16'd0;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        sel;
    logic        uart_txd;
    logic        irq;

    int          n_checks;
    int          n_fail;
    logic [119:0] cap;
    logic [7:0]  exp_q[$];

    waffle_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (1000),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .din     (din),
        .dout    (dout),
        .sel     (sel),
        .uart_txd(uart_txd),
        .irq     (irq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Checker
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: each starts and ends on a falling edge
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        we   = 1'b1;
        din  = d;
        @(negedge clk);
        we   = 1'b0;
        addr = NO_ADDR;
        din  = 8'd0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        d    = dout;
        s    = sel;
        addr = NO_ADDR;
    endtask

    task automatic capture(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[from + i] = uart_txd;
        end
    endtask

    // Expected line level per cycle of one frame; bit i is the i-th cycle after the start edge
    function automatic logic [39:0] frame_of(input logic [7:0] b);
        logic [39:0] w;
        for (int i = 0; i < 40; i++) begin
            int slot;
            slot = i / CPB;
            if (slot == 0)      w[i] = 1'b0;
            else if (slot == 9) w[i] = 1'b1;
            else                w[i] = b[slot - 1];
        end
        return w;
    endfunction

    logic [7:0] rd;
    logic       rs;
    logic       saw_low;
    logic [7:0] eb;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        addr     = NO_ADDR;
        we       = 1'b0;
        din      = 8'd0;
        cap      = '0;
        @(negedge clk);
        apply_reset();

        // Reset state
        check_eq("rst_dout", 64'(dout), 64'h00);
        check_eq("rst_sel", 64'(sel), 64'h0);
        check_eq("rst_txd", 64'(uart_txd), 64'h1);
        check_eq("rst_irq", 64'(irq), 64'h0);
        bus_read(16'd1001, rd, rs);
        check_eq("rst_status", 64'(rd), 64'h02);

        // Single frame 0x55
        bus_write(16'd1000, 8'h55);
        capture(0, 40);
        check_eq("frame_55", 64'(cap[39:0]), 64'(frame_of(8'h55)));
        @(negedge clk);
        check_eq("idle_txd_55", 64'(uart_txd), 64'h1);
        bus_read(16'd1001, rd, rs);
        check_eq("status_after_55", 64'(rd), 64'h02);

        // Three back-to-back frames from consecutive writes
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        bus_write(16'd1000, 8'hA1);
        bus_write(16'd1000, 8'h02);
        cap[0] = uart_txd;
        bus_write(16'd1000, 8'h03);
        cap[1] = uart_txd;
        capture(2, 118);
        for (int f = 0; f < 3; f++) begin
            eb = exp_q.pop_front();
            check_eq($sformatf("b2b_frame%0d", f), 64'(cap[f*40 +: 40]), 64'(frame_of(eb)));
        end
        @(negedge clk);
        check_eq("b2b_idle_txd", 64'(uart_txd), 64'h1);
        bus_read(16'd1001, rd, rs);
        check_eq("b2b_status", 64'(rd), 64'h02);

        // Fill FIFO while the first frame is still in flight, then overflow
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            bus_write(16'd1000, 8'(8'h10 + i));
        end
        bus_read(16'd1001, rd, rs);
        check_eq("full_status", 64'(rd), 64'h85);
        check_eq("full_sel", 64'(rs), 64'h1);
        bus_write(16'd1000, 8'hEE);
        bus_read(16'd1001, rd, rs);
        check_eq("ovf_status", 64'(rd), 64'h8D);
        bus_write(16'd1001, 8'h08);
        bus_read(16'd1001, rd, rs);
        check_eq("ovf_cleared", 64'(rd), 64'h85);
        repeat (27) @(negedge clk);
        capture(0, 40);
        check_eq("fifo_second_frame", 64'(cap[39:0]), 64'(frame_of(8'h11)));

        // Interrupt: enable with FIFO empty, drop on write, return after stop bit
        apply_reset();
        bus_write(16'd1002, 8'h01);
        check_eq("irq_enabled_idle", 64'(irq), 64'h1);
        bus_write(16'd1000, 8'h3C);
        check_eq("irq_after_write", 64'(irq), 64'h0);
        repeat (40) @(negedge clk);
        check_eq("irq_during_stop", 64'(irq), 64'h0);
        @(negedge clk);
        check_eq("irq_after_stop", 64'(irq), 64'h1);
        bus_read(16'd1002, rd, rs);
        check_eq("ctrl_read", 64'(rd), 64'h01);

        // Reset in the middle of data bit 3 of 0xF0 (bit 3 is 0)
        apply_reset();
        bus_write(16'd1000, 8'hF0);
        repeat (18) @(negedge clk);
        check_eq("mid_bit3_txd", 64'(uart_txd), 64'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("reset_txd_high", 64'(uart_txd), 64'h1);
        bus_read(16'd1001, rd, rs);
        check_eq("reset_status", 64'(rd), 64'h02);
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) saw_low = 1'b1;
        end
        check_eq("no_frame_after_reset", 64'(saw_low), 64'h0);

        // Address decode
        bus_read(16'd999, rd, rs);
        check_eq("rd999_sel", 64'(rs), 64'h0);
        check_eq("rd999_dout", 64'(rd), 64'h00);
        bus_read(16'd998, rd, rs);
        check_eq("rd998_sel", 64'(rs), 64'h0);
        check_eq("rd998_dout", 64'(rd), 64'h00);
        bus_read(16'd1003, rd, rs);
        check_eq("rd1003_sel", 64'(rs), 64'h0);
        check_eq("rd1003_dout", 64'(rd), 64'h00);
        bus_read(16'd1000, rd, rs);
        check_eq("rd1000_sel", 64'(rs), 64'h1);
        check_eq("rd1000_dout", 64'(rd), 64'h00);
        bus_write(16'd999, 8'h42);
        bus_read(16'd1001, rd, rs);
        check_eq("foreign_write_ignored", 64'(rd), 64'h02);
        bus_write(16'd1002, 8'hFF);
        bus_read(16'd1002, rd, rs);
        check_eq("ctrl_ff_reads_01", 64'(rd), 64'h01);
        check_eq("ctrl_sel", 64'(rs), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
